// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_pkg
// Brief   : Shared types and board constants for the CPU clock controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2
  } cpu_state_e;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int DEF_RUN_DIV         = 262_144;

  // Counter width that stays legal (>= 1 bit) for degenerate counts.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
//------------------------------------------------------------------------------
// Module  : key_debounce
// Brief   : Synchronises and debounces one active-low key; pulses on press.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  assign w_accept = (r_sync != r_stable) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta  <= key_n;
      r_sync  <= r_meta;
      // Only a newly accepted low level is a press; releases are silent.
      r_press <= w_accept & ~r_sync;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
//------------------------------------------------------------------------------
// Module  : cpu_clk_ctrl
// Brief   : RUN/STEP/HALT controller producing the CPU clock-enable tick.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_clk_ctrl
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RUN_DIV         = DEF_RUN_DIV,
  parameter int TCNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_run,
  input  logic              key_step,
  input  logic              cpu_hlt,
  output logic              tick,
  output logic              running,
  output logic              halted,
  output logic [TCNT_W-1:0] tick_count
);

  localparam int DIV_W = cnt_width(RUN_DIV);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(RUN_DIV - 1);

  logic              w_run_press;
  logic              w_step_press;
  cpu_state_e        r_state;
  cpu_state_e        w_next_state;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_next;
  logic              w_tick_next;
  logic              r_tick;
  logic              r_running;
  logic              r_halted;
  logic [TCNT_W-1:0] r_tick_count;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_run (
    .clk   (clk),
    .reset (reset),
    .key_n (key_run),
    .press (w_run_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_step (
    .clk   (clk),
    .reset (reset),
    .key_n (key_step),
    .press (w_step_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STOPPED;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Halt overrides every key event and any tick falling due the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_tick_next  = 1'b0;
    w_div_next   = '0;
    if (cpu_hlt) begin
      w_next_state = HALTED;
    end else begin
      case (r_state)
        STOPPED: begin
          if (w_run_press) begin
            w_next_state = RUN;
          end else if (w_step_press) begin
            w_tick_next = 1'b1;
          end
        end
        RUN: begin
          if (w_run_press) begin
            w_next_state = STOPPED;
          end else if (r_div == c_div_last) begin
            w_tick_next = 1'b1;
          end else begin
            w_div_next = r_div + DIV_W'(1);
          end
        end
        HALTED: begin
          w_next_state = STOPPED;
        end
        default: begin
          w_next_state = STOPPED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div        <= '0;
      r_tick       <= 1'b0;
      r_running    <= 1'b0;
      r_halted     <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_div        <= w_div_next;
      r_tick       <= w_tick_next;
      r_running    <= (w_next_state == RUN);
      r_halted     <= (w_next_state == HALTED);
      r_tick_count <= r_tick_count + TCNT_W'(w_tick_next);
    end
  end

  assign tick       = r_tick;
  assign running    = r_running;
  assign halted     = r_halted;
  assign tick_count = r_tick_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_cpu_clk_ctrl
// Brief   : Directed self-checking bench for cpu_clk_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_clk_ctrl;

  localparam int TCNT_W = 4;

  logic              clk;
  logic              reset;
  logic              key_run;
  logic              key_step;
  logic              cpu_hlt;
  logic              tick;
  logic              running;
  logic              halted;
  logic [TCNT_W-1:0] tick_count;

  int n_vec;
  int n_miss;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .RUN_DIV         (8),
    .TCNT_W          (TCNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_run    (key_run),
    .key_step   (key_step),
    .cpu_hlt    (cpu_hlt),
    .tick       (tick),
    .running    (running),
    .halted     (halted),
    .tick_count (tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    key_run  = 1'b1;
    key_step = 1'b1;
    cpu_hlt  = 1'b0;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    key_run  = 1'b1;
    key_step = 1'b1;
    cpu_hlt  = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({tick, running, halted, tick_count} !== 7'd0) begin
      n_miss++;
      $display("FAIL reset_hold: got %b expected 0", {tick, running, halted, tick_count});
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({tick, running, halted, tick_count} !== 7'd0) begin
      n_miss++;
      $display("FAIL reset_idle: got %b expected 0", {tick, running, halted, tick_count});
    end
  endtask

  task automatic test_step();
    int first;
    int cnt;
    do_reset();
    first = -1;
    cnt   = 0;
    key_step = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (tick) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k == 10) key_step = 1'b1;
    end
    n_vec++;
    if (first !== 7) begin
      n_miss++;
      $display("FAIL step_latency: got %0d expected 7", first);
    end
    n_vec++;
    if (cnt !== 1) begin
      n_miss++;
      $display("FAIL step_ticks: got %0d expected 1", cnt);
    end
    n_vec++;
    if (tick_count !== 4'd1 || running !== 1'b0) begin
      n_miss++;
      $display("FAIL step_state: got count %0d running %b expected 1 0", tick_count, running);
    end
  endtask

  task automatic test_bounce();
    int cnt;
    do_reset();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      key_step = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (tick) cnt++;
    end
    key_step = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tick) cnt++;
    end
    n_vec++;
    if (cnt !== 0 || tick_count !== 4'd0) begin
      n_miss++;
      $display("FAIL bounce: got ticks %0d count %0d expected 0 0", cnt, tick_count);
    end
  endtask

  task automatic test_run_stop();
    logic exp_tick;
    logic exp_run;
    do_reset();
    key_run = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      exp_tick = (k == 15) || (k == 23) || (k == 31) || (k == 39) || (k == 47);
      exp_run  = (k >= 7) && (k <= 54);
      n_vec++;
      if (tick !== exp_tick) begin
        n_miss++;
        $display("FAIL run_tick@%0d: got %b expected %b", k, tick, exp_tick);
      end
      n_vec++;
      if (running !== exp_run) begin
        n_miss++;
        $display("FAIL run_running@%0d: got %b expected %b", k, running, exp_run);
      end
      if (k == 10) key_run = 1'b1;
      if (k == 20) key_step = 1'b0;
      if (k == 30) key_step = 1'b1;
      if (k == 48) key_run = 1'b0;
      if (k == 58) key_run = 1'b1;
    end
    n_vec++;
    if (tick_count !== 4'd5) begin
      n_miss++;
      $display("FAIL run_count: got %0d expected 5", tick_count);
    end
  endtask

  task automatic test_halt();
    int cnt;
    do_reset();
    cnt = 0;
    key_run = 1'b0;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      if (tick) cnt++;
      if (k == 10) key_run = 1'b1;
      if (k == 14) begin
        n_vec++;
        if (running !== 1'b1 || tick !== 1'b0) begin
          n_miss++;
          $display("FAIL halt_pre: got running %b tick %b expected 1 0", running, tick);
        end
        cpu_hlt = 1'b1;
      end
      if (k >= 15 && k <= 40) begin
        n_vec++;
        if (halted !== 1'b1 || running !== 1'b0 || tick !== 1'b0) begin
          n_miss++;
          $display("FAIL halt_hold@%0d: got halted %b running %b tick %b expected 1 0 0",
                   k, halted, running, tick);
        end
      end
      if (k == 16) begin
        key_run  = 1'b0;
        key_step = 1'b0;
      end
      if (k == 26) begin
        key_run  = 1'b1;
        key_step = 1'b1;
      end
      if (k == 40) cpu_hlt = 1'b0;
      if (k >= 41) begin
        n_vec++;
        if (halted !== 1'b0 || running !== 1'b0) begin
          n_miss++;
          $display("FAIL halt_exit@%0d: got halted %b running %b expected 0 0", k, halted, running);
        end
      end
    end
    n_vec++;
    if (cnt !== 0 || tick_count !== 4'd0) begin
      n_miss++;
      $display("FAIL halt_ticks: got ticks %0d count %0d expected 0 0", cnt, tick_count);
    end
  endtask

  task automatic test_wrap_reset();
    int cnt;
    do_reset();
    cnt = 0;
    for (int s = 0; s < 17; s++) begin
      key_step = 1'b0;
      for (int j = 1; j <= 18; j++) begin
        @(negedge clk);
        if (tick) cnt++;
        if (j == 8) key_step = 1'b1;
      end
    end
    n_vec++;
    if (cnt !== 17 || tick_count !== 4'd1) begin
      n_miss++;
      $display("FAIL wrap: got ticks %0d count %0d expected 17 1", cnt, tick_count);
    end
    key_run = 1'b0;
    repeat (10) @(negedge clk);
    key_run = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (running !== 1'b1) begin
      n_miss++;
      $display("FAIL wrap_run: got %b expected 1", running);
    end
    key_run = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({tick, running, halted, tick_count} !== 7'd0) begin
      n_miss++;
      $display("FAIL async_reset: got %b expected 0", {tick, running, halted, tick_count});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) begin
        n_vec++;
        if (running !== 1'b0) begin
          n_miss++;
          $display("FAIL held_key_early: got %b expected 0", running);
        end
      end
      if (k == 7) begin
        n_vec++;
        if (running !== 1'b1) begin
          n_miss++;
          $display("FAIL held_key_press: got %b expected 1", running);
        end
      end
    end
    key_run = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if (running !== 1'b1) begin
      n_miss++;
      $display("FAIL held_key_single: got %b expected 1", running);
    end
  endtask

  task automatic test_simultaneous();
    logic exp_tick;
    do_reset();
    key_run  = 1'b0;
    key_step = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_tick = (k == 15);
      n_vec++;
      if (tick !== exp_tick) begin
        n_miss++;
        $display("FAIL simul_tick@%0d: got %b expected %b", k, tick, exp_tick);
      end
      if (k == 7) begin
        n_vec++;
        if (running !== 1'b1) begin
          n_miss++;
          $display("FAIL simul_running: got %b expected 1", running);
        end
      end
      if (k == 10) begin
        key_run  = 1'b1;
        key_step = 1'b1;
      end
    end
    n_vec++;
    if (tick_count !== 4'd1) begin
      n_miss++;
      $display("FAIL simul_count: got %0d expected 1", tick_count);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    reset    = 1'b0;
    key_run  = 1'b1;
    key_step = 1'b1;
    cpu_hlt  = 1'b0;
    test_reset();
    test_step();
    test_bounce();
    test_run_stop();
    test_halt();
    test_wrap_reset();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
